// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
//
// Purpose:
//   Groups the interrupt sequencer's command, request and CPU handshake signals
//   into one bundle. The clock and reset stay plain ports on the module.
//
// Signals (direction seen from the sequencer, modport slave):
//   write_initial_command_word_1_reset  in   ICW1 write; synchronous clear
//   interrupt_request_register          in   [7:0] pending requests (IRR)
//   interrupt_mask                      in   [7:0] OCW1 mask, 1 = masked
//   interrupt_acknowledge_n             in   INTA#, already synchronous
//   interrupt_vector_base               in   [4:0] ICW2 T7..T3
//   auto_eoi_config                     in   ICW4 AEOI
//   end_of_interrupt                    in   one-cycle OCW2 EOI pulse
//   specific_eoi                        in   1 = specific EOI
//   eoi_level                           in   [2:0] level for a specific EOI
//   interrupt_to_cpu                    out  INT pin
//   freeze                              out  holds the IRR during acknowledge
//   clear_interrupt_request             out  [7:0] one-cycle IRR clear
//   in_service_register                 out  [7:0] ISR
//   interrupt_vector                    out  [7:0] vector byte
//   interrupt_vector_enable             out  vector valid / bus drive request
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding PIC logic (or a testbench) driving it
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if;
  logic       write_initial_command_word_1_reset;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt_mask;
  logic       interrupt_acknowledge_n;
  logic [4:0] interrupt_vector_base;
  logic       auto_eoi_config;
  logic       end_of_interrupt;
  logic       specific_eoi;
  logic [2:0] eoi_level;
  logic       interrupt_to_cpu;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] interrupt_vector;
  logic       interrupt_vector_enable;

  modport slave (
    input  write_initial_command_word_1_reset,
    input  interrupt_request_register,
    input  interrupt_mask,
    input  interrupt_acknowledge_n,
    input  interrupt_vector_base,
    input  auto_eoi_config,
    input  end_of_interrupt,
    input  specific_eoi,
    input  eoi_level,
    output interrupt_to_cpu,
    output freeze,
    output clear_interrupt_request,
    output in_service_register,
    output interrupt_vector,
    output interrupt_vector_enable
  );

  modport master (
    output write_initial_command_word_1_reset,
    output interrupt_request_register,
    output interrupt_mask,
    output interrupt_acknowledge_n,
    output interrupt_vector_base,
    output auto_eoi_config,
    output end_of_interrupt,
    output specific_eoi,
    output eoi_level,
    input  interrupt_to_cpu,
    input  freeze,
    input  clear_interrupt_request,
    input  in_service_register,
    input  interrupt_vector,
    input  interrupt_vector_enable
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Purpose:
//   Interrupt sequencing controller of an 8259-compatible PIC. Resolves
//   priority among unmasked pending requests, raises INT, runs the two-pulse
//   8086-mode INTA# handshake, keeps the in-service register and drives the
//   vector byte {base[4:0], level[2:0]}.
//
// Ports:
//   clock    in  system clock, all state updates on the rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      interrupt_sequencer_if.slave (command inputs, IRR, INTA#,
//            INT, freeze, IRR clear, ISR and vector outputs)
//
// Configuration:
//   PIC_ROTATE_ON_EOI_EN  when defined, a non-specific EOI or an AEOI
//                         completion on level k makes k the lowest-priority
//                         level (automatic rotation). When undefined the
//                         lowest-priority level is fixed at 7 (IR0 highest).
// -----------------------------------------------------------------------------
module interrupt_sequencer (
  input  logic                   clock,
  input  logic                   reset_n,
  interrupt_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACK1_WAIT,
    ACK1_ACTIVE,
    ACK2_WAIT,
    ACK2_ACTIVE
  } state_t;

  state_t     state_reg;
  logic       inta_prev_reg;
  logic       int_reg;
  logic       freeze_reg;
  logic [7:0] clear_request_reg;
  logic [7:0] isr_reg;
  logic [7:0] vector_reg;
  logic       vector_enable_reg;
  logic [2:0] ack_level_reg;
  logic       spurious_reg;

  logic [2:0] lowest_priority_level;

  // ---------------------------------------------------------------------------
  // Priority resolution
  //
  // Both the pending vector and the ISR are rotated so that bit 0 holds the
  // highest-priority level (lowest_priority_level + 1). A plain "lowest set
  // bit" search on the rotated vectors then yields priority ranks, and the
  // rank comparison directly answers "does the request outrank the ISR".
  // ---------------------------------------------------------------------------
  logic [7:0] pending;
  logic [2:0] rot_shift;
  logic [7:0] pending_rot;
  logic [7:0] isr_rot;

  assign pending   = bus.interrupt_request_register & ~bus.interrupt_mask;
  assign rot_shift = lowest_priority_level + 3'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rotate
      // 3-bit index arithmetic wraps modulo 8 naturally.
      assign pending_rot[gi] = pending[3'(gi) + rot_shift];
      assign isr_rot[gi]     = isr_reg[3'(gi) + rot_shift];
    end
  endgenerate

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] first_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] pending_first;
  logic [3:0] isr_first;
  logic       pending_found;
  logic       isr_found;
  logic [2:0] pending_rank;
  logic [2:0] isr_rank;
  logic [2:0] highest_pending_level;
  logic [2:0] highest_isr_level;
  logic       request_valid;

  assign pending_first         = first_set(pending_rot);
  assign isr_first             = first_set(isr_rot);
  assign pending_found         = pending_first[3];
  assign isr_found             = isr_first[3];
  assign pending_rank          = pending_first[2:0];
  assign isr_rank              = isr_first[2:0];
  assign highest_pending_level = pending_rank + rot_shift;
  assign highest_isr_level     = isr_rank + rot_shift;

  // A request equal in priority to the highest in-service level does not
  // interrupt it; only strictly higher priority nests.
  assign request_valid = pending_found && (!isr_found || (pending_rank < isr_rank));

  // ---------------------------------------------------------------------------
  // INTA# edge detection against the previous sampled value
  // ---------------------------------------------------------------------------
  logic inta_fall;
  logic inta_rise;

  assign inta_fall = inta_prev_reg & ~bus.interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev_reg & bus.interrupt_acknowledge_n;

  // ---------------------------------------------------------------------------
  // ISR set/clear masks for this cycle. Set wins over clear on the same bit;
  // clears on other bits still apply in the same cycle.
  // ---------------------------------------------------------------------------
  logic [7:0] isr_set_mask;
  logic [7:0] isr_clear_mask;
  logic [7:0] isr_next;
  logic       aeoi_complete;
  logic       nonspecific_hit;

  assign aeoi_complete   = (state_reg == ACK2_ACTIVE) && inta_rise &&
                           bus.auto_eoi_config && !spurious_reg;
  assign nonspecific_hit = bus.end_of_interrupt && !bus.specific_eoi && isr_found;

  always_comb begin
    isr_set_mask   = 8'h00;
    isr_clear_mask = 8'h00;
    if ((state_reg == ACK1_WAIT) && inta_fall && pending_found) begin
      isr_set_mask = 8'(1) << highest_pending_level;
    end
    if (bus.end_of_interrupt && bus.specific_eoi) begin
      isr_clear_mask = isr_clear_mask | (8'(1) << bus.eoi_level);
    end
    if (nonspecific_hit) begin
      isr_clear_mask = isr_clear_mask | (8'(1) << highest_isr_level);
    end
    if (aeoi_complete) begin
      isr_clear_mask = isr_clear_mask | (8'(1) << ack_level_reg);
    end
  end

  assign isr_next = (isr_reg & ~isr_clear_mask) | isr_set_mask;

  // ---------------------------------------------------------------------------
  // Lowest-priority level (rotation)
  // ---------------------------------------------------------------------------
`ifdef PIC_ROTATE_ON_EOI_EN
  logic [2:0] lowest_priority_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lowest_priority_reg <= 3'd7;
    end else if (bus.write_initial_command_word_1_reset) begin
      lowest_priority_reg <= 3'd7;
    end else if (aeoi_complete) begin
      // AEOI completion and a non-specific EOI in the same cycle both rotate;
      // the acknowledge that just finished is the more recent service.
      lowest_priority_reg <= ack_level_reg;
    end else if (nonspecific_hit) begin
      lowest_priority_reg <= highest_isr_level;
    end
  end

  assign lowest_priority_level = lowest_priority_reg;
`else
  assign lowest_priority_level = 3'd7;
`endif

  // ---------------------------------------------------------------------------
  // Acknowledge sequencer with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      inta_prev_reg     <= 1'b1;
      int_reg           <= 1'b0;
      freeze_reg        <= 1'b0;
      clear_request_reg <= 8'h00;
      isr_reg           <= 8'h00;
      vector_reg        <= 8'h00;
      vector_enable_reg <= 1'b0;
      ack_level_reg     <= 3'd0;
      spurious_reg      <= 1'b0;
    end else if (bus.write_initial_command_word_1_reset) begin
      state_reg         <= IDLE;
      inta_prev_reg     <= 1'b1;
      int_reg           <= 1'b0;
      freeze_reg        <= 1'b0;
      clear_request_reg <= 8'h00;
      isr_reg           <= 8'h00;
      vector_reg        <= 8'h00;
      vector_enable_reg <= 1'b0;
      ack_level_reg     <= 3'd0;
      spurious_reg      <= 1'b0;
    end else begin
      inta_prev_reg     <= bus.interrupt_acknowledge_n;
      clear_request_reg <= 8'h00;
      isr_reg           <= isr_next;

      case (state_reg)
        IDLE: begin
          if (request_valid) begin
            int_reg   <= 1'b1;
            state_reg <= ACK1_WAIT;
          end
        end

        // INT is held even if the request goes away; the first INTA# then
        // resolves to a spurious level-7 acknowledge.
        ACK1_WAIT: begin
          if (inta_fall) begin
            int_reg    <= 1'b0;
            freeze_reg <= 1'b1;
            if (pending_found) begin
              ack_level_reg     <= highest_pending_level;
              spurious_reg      <= 1'b0;
              clear_request_reg <= 8'(1) << highest_pending_level;
            end else begin
              ack_level_reg <= 3'd7;
              spurious_reg  <= 1'b1;
            end
            state_reg <= ACK1_ACTIVE;
          end
        end

        ACK1_ACTIVE: begin
          if (inta_rise) begin
            state_reg <= ACK2_WAIT;
          end
        end

        ACK2_WAIT: begin
          if (inta_fall) begin
            vector_reg        <= {bus.interrupt_vector_base, ack_level_reg};
            vector_enable_reg <= 1'b1;
            state_reg         <= ACK2_ACTIVE;
          end
        end

        ACK2_ACTIVE: begin
          if (inta_rise) begin
            vector_enable_reg <= 1'b0;
            freeze_reg        <= 1'b0;
            state_reg         <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.interrupt_to_cpu        = int_reg;
  assign bus.freeze                  = freeze_reg;
  assign bus.clear_interrupt_request = clear_request_reg;
  assign bus.in_service_register     = isr_reg;
  assign bus.interrupt_vector        = vector_reg;
  assign bus.interrupt_vector_enable = vector_enable_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Directed scenarios followed by randomized acknowledge/EOI traffic. Expected
// values come from a behavioural model: the ISR as a bit vector plus a
// lowest-priority level, with priority found by walking levels in order.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_isr = 8'h00;
  int         m_lpl = 7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Highest-priority set level in v, or -1 if none.
  function automatic int model_highest(input logic [7:0] v, input int lpl);
    for (int i = 0; i < 8; i++) begin
      int lvl;
      lvl = (lpl + 1 + i) % 8;
      if (v[lvl]) return lvl;
    end
    return -1;
  endfunction

  // 0 = highest priority, 7 = lowest.
  function automatic int model_rank(input int lvl, input int lpl);
    return (lvl - lpl - 1 + 16) % 8;
  endfunction

  task automatic model_reset();
    m_isr = 8'h00;
    m_lpl = 7;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Presents a request and, if the model says it is serviceable, runs the full
  // two-pulse INTA# handshake. With drop=1 the request is withdrawn after INT
  // rises, which must produce a spurious acknowledge.
  task automatic handshake(input logic [7:0] irr_v, input logic [7:0] mask_v,
                           input logic [4:0] base_v, input logic aeoi_v,
                           input logic drop, input string tag);
    logic [7:0] pend;
    int         hp;
    int         hi;
    int         lvl;
    bit         valid;
    bit         spur;
    logic [7:0] exp_clr;

    bus.interrupt_vector_base      = base_v;
    bus.auto_eoi_config            = aeoi_v;
    bus.interrupt_mask             = mask_v;
    bus.interrupt_request_register = irr_v;
    pend  = irr_v & ~mask_v;
    hp    = model_highest(pend, m_lpl);
    hi    = model_highest(m_isr, m_lpl);
    valid = (hp >= 0) && ((hi < 0) || (model_rank(hp, m_lpl) < model_rank(hi, m_lpl)));
    tick();
    chk({tag, " int_rise"}, 32'(bus.interrupt_to_cpu), 32'(valid));
    if (!valid) begin
      tick();
      chk({tag, " int_low"}, 32'(bus.interrupt_to_cpu), 32'(0));
      bus.interrupt_request_register = 8'h00;
      tick();
      $display("txn %s: no interrupt, isr=0x%02h", tag, m_isr);
      return;
    end
    if (drop) begin
      bus.interrupt_request_register = 8'h00;
      pend = 8'h00;
      tick();
      chk({tag, " int_held"}, 32'(bus.interrupt_to_cpu), 32'(1));
    end

    hp   = model_highest(pend, m_lpl);
    spur = (hp < 0);
    lvl  = spur ? 7 : hp;
    exp_clr = spur ? 8'h00 : 8'(1 << lvl);

    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    if (!spur) m_isr[lvl] = 1'b1;
    chk({tag, " isr_set"}, 32'(bus.in_service_register), 32'(m_isr));
    chk({tag, " clr_pulse"}, 32'(bus.clear_interrupt_request), 32'(exp_clr));
    chk({tag, " int_drop"}, 32'(bus.interrupt_to_cpu), 32'(0));
    chk({tag, " freeze_on"}, 32'(bus.freeze), 32'(1));

    bus.interrupt_request_register = bus.interrupt_request_register & ~exp_clr;
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    chk({tag, " clr_one_cycle"}, 32'(bus.clear_interrupt_request), 32'(0));

    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    chk({tag, " vector"}, 32'(bus.interrupt_vector), 32'({base_v, 3'(lvl)}));
    chk({tag, " enable_on"}, 32'(bus.interrupt_vector_enable), 32'(1));
    tick();
    chk({tag, " enable_held"}, 32'(bus.interrupt_vector_enable), 32'(1));

    bus.interrupt_acknowledge_n    = 1'b1;
    bus.interrupt_request_register = 8'h00;
    tick();
    if (aeoi_v && !spur) begin
      m_isr[lvl] = 1'b0;
`ifdef PIC_ROTATE_ON_EOI_EN
      m_lpl = lvl;
`endif
    end
    chk({tag, " enable_off"}, 32'(bus.interrupt_vector_enable), 32'(0));
    chk({tag, " freeze_off"}, 32'(bus.freeze), 32'(0));
    chk({tag, " isr_end"}, 32'(bus.in_service_register), 32'(m_isr));
    $display("txn %s: level=%0d spurious=%0d vector=0x%02h isr=0x%02h",
             tag, lvl, spur, bus.interrupt_vector, m_isr);
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input string tag);
    int k;
    bus.end_of_interrupt = 1'b1;
    bus.specific_eoi     = spec;
    bus.eoi_level        = lvl;
    tick();
    bus.end_of_interrupt = 1'b0;
    if (spec) begin
      m_isr[lvl] = 1'b0;
    end else begin
      k = model_highest(m_isr, m_lpl);
      if (k >= 0) begin
        m_isr[k] = 1'b0;
`ifdef PIC_ROTATE_ON_EOI_EN
        m_lpl = k;
`endif
      end
    end
    chk({tag, " isr"}, 32'(bus.in_service_register), 32'(m_isr));
    $display("txn %s: eoi specific=%0d level=%0d isr=0x%02h", tag, spec, lvl, m_isr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_initial_command_word_1_reset = 1'b0;
    bus.interrupt_request_register         = 8'h00;
    bus.interrupt_mask                     = 8'h00;
    bus.interrupt_acknowledge_n            = 1'b1;
    bus.interrupt_vector_base              = 5'h00;
    bus.auto_eoi_config                    = 1'b0;
    bus.end_of_interrupt                   = 1'b0;
    bus.specific_eoi                       = 1'b0;
    bus.eoi_level                          = 3'd0;

    // Reset state
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("reset int", 32'(bus.interrupt_to_cpu), 32'(0));
    chk("reset freeze", 32'(bus.freeze), 32'(0));
    chk("reset clr", 32'(bus.clear_interrupt_request), 32'(0));
    chk("reset isr", 32'(bus.in_service_register), 32'(0));
    chk("reset vector", 32'(bus.interrupt_vector), 32'(0));
    chk("reset enable", 32'(bus.interrupt_vector_enable), 32'(0));
    reset_n = 1'b1;
    model_reset();
    tick();

    // INTA# low while idle must be ignored
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    tick();
    chk("idle_inta freeze", 32'(bus.freeze), 32'(0));
    chk("idle_inta enable", 32'(bus.interrupt_vector_enable), 32'(0));
    chk("idle_inta isr", 32'(bus.in_service_register), 32'(0));
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    $display("txn idle_inta: ignored");

    // Basic acknowledge: IR3, base 0x11 -> vector 0x8B
    handshake(8'h08, 8'h00, 5'h11, 1'b0, 1'b0, "basic");
    chk("basic vector_const", 32'(bus.interrupt_vector), 32'(8'h8B));
    eoi(1'b1, 3'd3, "basic_eoi");

    // Priority and nesting
    handshake(8'h04, 8'h00, 5'h02, 1'b0, 1'b0, "nest_ir2");
    handshake(8'h20, 8'h00, 5'h02, 1'b0, 1'b0, "nest_ir5_blocked");
    handshake(8'h02, 8'h00, 5'h02, 1'b0, 1'b0, "nest_ir1");
    chk("nest isr_const", 32'(bus.in_service_register), 32'(8'h06));
    eoi(1'b1, 3'd1, "nest_eoi1");
    eoi(1'b1, 3'd2, "nest_eoi2");

    // Masked request is not serviced
    handshake(8'h10, 8'h10, 5'h02, 1'b0, 1'b0, "masked");

    // Spurious
    handshake(8'h01, 8'h00, 5'h15, 1'b0, 1'b1, "spurious");
    chk("spurious vector_const", 32'(bus.interrupt_vector), 32'(8'hAF));

    // AEOI
    handshake(8'h08, 8'h00, 5'h11, 1'b1, 1'b0, "aeoi_ir3");

    // Non-specific EOI with ISR=0x28
    do_reset();
    handshake(8'h20, 8'h00, 5'h04, 1'b0, 1'b0, "nseoi_ir5");
    handshake(8'h08, 8'h00, 5'h04, 1'b0, 1'b0, "nseoi_ir3");
    eoi(1'b0, 3'd0, "nseoi");
    chk("nseoi isr_const", 32'(bus.in_service_register), 32'(8'h20));

    // Rotation: non-specific EOI on IR4, then IRR=0x21
    do_reset();
    handshake(8'h10, 8'h00, 5'h08, 1'b0, 1'b0, "rot_ir4");
    eoi(1'b0, 3'd0, "rot_eoi");
    handshake(8'h21, 8'h00, 5'h08, 1'b0, 1'b0, "rot_pick");
`ifdef PIC_ROTATE_ON_EOI_EN
    chk("rot level", 32'(bus.interrupt_vector), 32'({5'h08, 3'd5}));
`else
    chk("rot level", 32'(bus.interrupt_vector), 32'({5'h08, 3'd0}));
`endif

    // Reset in ACK2_ACTIVE
    do_reset();
    bus.interrupt_request_register = 8'h02;
    tick();
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    chk("midrst enable_before", 32'(bus.interrupt_vector_enable), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst enable", 32'(bus.interrupt_vector_enable), 32'(0));
    chk("midrst freeze", 32'(bus.freeze), 32'(0));
    chk("midrst isr", 32'(bus.in_service_register), 32'(0));
    bus.interrupt_acknowledge_n    = 1'b1;
    bus.interrupt_request_register = 8'h00;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    $display("txn midrst: outputs cleared");
    handshake(8'h40, 8'h00, 5'h1F, 1'b0, 1'b0, "after_rst");

    // ICW1 with ISR=0xFF
    do_reset();
    for (int l = 7; l >= 0; l--) begin
      handshake(8'(1 << l), 8'h00, 5'h03, 1'b0, 1'b0, "fill");
    end
    chk("icw1 isr_full", 32'(bus.in_service_register), 32'(8'hFF));
    bus.write_initial_command_word_1_reset = 1'b1;
    tick();
    bus.write_initial_command_word_1_reset = 1'b0;
    model_reset();
    chk("icw1 isr", 32'(bus.in_service_register), 32'(0));
    $display("txn icw1: isr cleared");

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      logic [7:0] irr_r;
      logic [7:0] mask_r;
      irr_r  = 8'($urandom);
      mask_r = 8'($urandom) & 8'($urandom);
      handshake(irr_r, mask_r, 5'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                "rand");
      if ($urandom_range(0, 1) == 1) begin
        eoi(1'($urandom), 3'($urandom), "rand_eoi");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Interrupt sequencing controller for the 8259-compatible PIC: it resolves priority among unmasked pending requests from the interrupt request register, raises INT to the CPU, runs the two-pulse 8086-mode INTA handshake, maintains the in-service register, and drives the vector byte. It sits between the interrupt request register (fed back through `freeze` and `clear_interrupt_request`) and the data-bus buffer.

## Interface
Parameters:
- none; the vector format is fixed at {base[4:0], level[2:0]}.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `write_initial_command_word_1_reset`  in  1  synchronous clear, same effect as reset; ICW1 write.
- `interrupt_request_register`  in  8  pending requests from the interrupt request register.
- `interrupt_mask`  in  8  OCW1 mask; 1 = masked.
- `interrupt_acknowledge_n`  in  1  INTA# pin, already synchronous to `clock`.
- `interrupt_vector_base`  in  5  ICW2 bits T7..T3.
- `auto_eoi_config`  in  1  ICW4 AEOI.
- `end_of_interrupt`  in  1  one-cycle EOI command pulse (OCW2).
- `specific_eoi`  in  1  qualifies `end_of_interrupt`; 1 = specific.
- `eoi_level`  in  3  level cleared by a specific EOI.
- `interrupt_to_cpu`  out  1  INT pin; registered.
- `freeze`  out  1  holds the interrupt request register during acknowledge.
- `clear_interrupt_request`  out  8  one-cycle clear of the acknowledged request bit.
- `in_service_register`  out  8  ISR.
- `interrupt_vector`  out  8  vector byte.
- `interrupt_vector_enable`  out  1  vector valid and bus drive request.

## Operation
- `pending = interrupt_request_register & ~interrupt_mask`.
- Priority: `lowest_priority_level` (3-bit, reset 7) marks the lowest-priority level. Level (lowest_priority_level+1) mod 8 is highest; priority decreases with increasing level modulo 8.
- `request_valid`: pending is non-zero, and the highest pending level outranks every set ISR bit (or ISR is zero).
- FSM states:
  - IDLE: if `request_valid`, assert INT and go to ACK1_WAIT.
  - ACK1_WAIT: INT stays high even if the request is withdrawn. On an INTA# falling edge (prev=1, now=0):
    - Latch `acknowledged_level` = highest pending level. If pending is zero, latch 7 as spurious.
    - If not spurious, set ISR[level] and pulse `clear_interrupt_request[level]`.
    - Drop INT, raise `freeze`, go to ACK1_ACTIVE.
  - ACK1_ACTIVE: on INTA# rising, go to ACK2_WAIT.
  - ACK2_WAIT: on INTA# falling, drive `interrupt_vector = {interrupt_vector_base, acknowledged_level}` with enable high, then go to ACK2_ACTIVE.
  - ACK2_ACTIVE: enable stays high while INTA# is low. On INTA# rising:
    - Drop enable and `freeze`.
    - If AEOI and not spurious, clear ISR[acknowledged_level].
    - Return to IDLE.
- EOI is accepted in any state:
  - Specific EOI clears ISR[eoi_level].
  - Non-specific EOI clears the highest-priority set ISR bit; no effect if ISR is zero.
- Same-cycle conflicts:
  - An ISR set beats a clear on the same bit.
  - A clear on another bit applies in the same cycle.
- `write_initial_command_word_1_reset`: same effect as reset in that cycle, and overrides everything else.

## Timing
- Reset values: `interrupt_to_cpu` 0, `freeze` 0, `clear_interrupt_request` 0, `in_service_register` 0, `interrupt_vector` 0, `interrupt_vector_enable` 0, `lowest_priority_level` 7, state IDLE, INTA# history 1.
- Latencies:
  - INT rises 1 cycle after `request_valid` is seen in IDLE.
  - ISR set, clear pulse, `freeze` and INT drop all register 1 cycle after the sampled INTA# falling edge.
  - Vector and enable are valid 1 cycle after the second falling edge and drop 1 cycle after its rising edge.
  - EOI takes effect on ISR 1 cycle after the pulse.
- `clear_interrupt_request` is high for exactly one cycle per real acknowledge.
- INTA# edges outside the expected state are ignored, for example INTA# low in IDLE.
- If reset asserts mid-handshake, all outputs return to reset values immediately and a new handshake starts from IDLE.

## Configuration
- `PIC_ROTATE_ON_EOI_EN` defined:
  - A non-specific EOI that clears level k sets `lowest_priority_level = k`.
  - An AEOI completion on level k also sets `lowest_priority_level = k`.
- `PIC_ROTATE_ON_EOI_EN` undefined: `lowest_priority_level` is constant 7, giving fixed priority with IR0 highest.

## Test plan
- Basic acknowledge:
  - Stimulus: IRR=0x08, mask=0, base=0x11, two INTA# pulses.
  - Required: INT high; after pulse 1, ISR=0x08, `clear_interrupt_request`=0x08 for one cycle, INT low; during pulse 2, vector=0x8B, enable high.
- Priority and nesting:
  - Stimulus: ISR=0x04 in service, then IRR=0x20. Next, IRR=0x02.
  - Required: with IRR=0x20, INT stays low; with IRR=0x02, INT rises and is acknowledged with vector level 1.
- Spurious request:
  - Stimulus: IRR=0x01 raises INT; IRR drops to 0 before the first INTA#.
  - Required: vector = {base, 3'd7}; ISR unchanged; no clear pulse.
- AEOI versus EOI:
  - Stimulus: AEOI=1, acknowledge IR3. Then AEOI=0 with ISR=0x28 and a non-specific EOI.
  - Required: with AEOI, ISR=0 after the second INTA# rise; with the non-specific EOI, ISR becomes 0x20.
- Rotation:
  - Stimulus: with `PIC_ROTATE_ON_EOI_EN`, a non-specific EOI clears IR4; then IRR=0x21.
  - Required: level 5 is acknowledged first. Without the macro, level 0 is acknowledged first.
- Reset and ICW1:
  - Stimulus: `reset_n` low during ACK2_ACTIVE. Separately, ICW1 pulse with ISR=0xFF.
  - Required: on reset, enable and `freeze` go 0 immediately and state returns to IDLE; on ICW1, ISR=0 next cycle.
